// File: rtl/ysyx_22040125_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and
// architectural constants.
package ysyx_22040125_pkg;

    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] IFU_NOP      = 32'h0000_0013;
    localparam int unsigned IFU_ENTRY_W  = 96;

    typedef enum logic [2:0] {
        IFU_IDLE      = 3'd0,
        IFU_REQ       = 3'd1,
        IFU_WAIT      = 3'd2,
        IFU_DROP_REQ  = 3'd3,
        IFU_DROP_WAIT = 3'd4
    } ifu_state_e;

endpackage

// File: rtl/ysyx_22040125_ifu_fifo.sv
// Instruction buffer: registered FIFO of {inst, pc} entries with flush.
// The head is read straight from storage so decode sees no memory-side paths.
module ysyx_22040125_ifu_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               push_data,
    output logic [WIDTH-1:0]               head_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty     = (cnt == '0);
    assign full      = (cnt == CNT_W'(DEPTH));
    assign count     = cnt;
    assign head_data = mem[rd_ptr];

    // A pop frees the slot a same-cycle push needs when the buffer is full.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_22040125_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding a small
// instruction buffer, with redirect handling that drains stale responses.
module ysyx_22040125_ifu
    import ysyx_22040125_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = IFU_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    localparam logic [63:0] RESET_PC_ALIGNED = RESET_PC & ~64'h3;

    ifu_state_e state;
    ifu_state_e state_nx;

    logic [63:0] fetch_pc;
    logic [63:0] fetch_pc_nx;
    logic [63:0] stale_addr;
    logic [63:0] stale_addr_nx;
    logic [63:0] redir_pc;

    logic                              fifo_push;
    logic                              fifo_pop;
    logic                              fifo_flush;
    logic                              fifo_full;
    logic                              fifo_empty;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;
    logic [IFU_ENTRY_W-1:0]            fifo_head;
    int unsigned                       occ_after;

    assign redir_pc   = redirect_pc & ~64'h3;
    assign inst_valid = ~fifo_empty;
    assign fifo_pop   = inst_valid & inst_ready;
    assign inst       = fifo_head[95:64];
    assign inst_pc    = fifo_head[63:0];
    assign occ_after  = 32'(fifo_count) + 32'd1 - 32'(fifo_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IFU_IDLE;
            fetch_pc   <= RESET_PC_ALIGNED;
            stale_addr <= RESET_PC_ALIGNED;
        end else begin
            state      <= state_nx;
            fetch_pc   <= fetch_pc_nx;
            stale_addr <= stale_addr_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        fetch_pc_nx   = fetch_pc;
        stale_addr_nx = stale_addr;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = fetch_pc;

        case (state)
            IFU_IDLE: begin
                if (redirect_valid) begin
                    fifo_flush  = 1'b1;
                    fetch_pc_nx = redir_pc;
                    state_nx    = IFU_REQ;
                end else if (!fifo_full) begin
                    state_nx = IFU_REQ;
                end
            end
            IFU_REQ: begin
                mem_req_valid = 1'b1;
                if (redirect_valid) begin
                    fifo_flush  = 1'b1;
                    fetch_pc_nx = redir_pc;
                    if (mem_req_ready) begin
                        state_nx = IFU_DROP_WAIT;
                    end else begin
                        // fetch_pc moves on, so the unaccepted old address is kept aside
                        stale_addr_nx = fetch_pc;
                        state_nx      = IFU_DROP_REQ;
                    end
                end else if (mem_req_ready) begin
                    state_nx = IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (redirect_valid) begin
                    fifo_flush  = 1'b1;
                    fetch_pc_nx = redir_pc;
                    state_nx    = mem_rsp_valid ? IFU_REQ : IFU_DROP_WAIT;
                end else if (mem_rsp_valid) begin
                    fifo_push   = 1'b1;
                    fetch_pc_nx = fetch_pc + 64'd4;
                    state_nx    = (occ_after < FIFO_DEPTH) ? IFU_REQ : IFU_IDLE;
                end
            end
            IFU_DROP_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = stale_addr;
                if (redirect_valid) begin
                    fetch_pc_nx = redir_pc;
                end
                if (mem_req_ready) begin
                    state_nx = IFU_DROP_WAIT;
                end
            end
            IFU_DROP_WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_nx = redir_pc;
                end
                if (mem_rsp_valid) begin
                    state_nx = IFU_REQ;
                end
            end
            default: state_nx = IFU_IDLE;
        endcase
    end

    ysyx_22040125_ifu_fifo #(
        .WIDTH (IFU_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .push_data ({mem_rsp_data, fetch_pc}),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_ysyx_22040125_ifu.sv
// Self-checking bench for the fetch unit: a memory responder, a PC-stream
// reference model checked every cycle, directed scenarios and random traffic.
module tb_ysyx_22040125_ifu;

    localparam logic [63:0] RST_PC   = 64'h0000_0000_8000_0000;
    localparam int unsigned TB_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;

    always #5 clk = ~clk;

    ysyx_22040125_ifu #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (TB_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: answers each accepted request after dly_min..dly_max cycles with addr[31:0].
    int unsigned dly_min = 1;
    int unsigned dly_max = 1;
    bit          pend = 1'b0;
    int unsigned pend_cnt = 0;
    logic [63:0] pend_addr = '0;

    initial forever begin
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
        if (pend) begin
            if (pend_cnt <= 1) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = pend_addr[31:0];
                pend          = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        #4;
        if (mem_req_valid && mem_req_ready) begin
            pend      = 1'b1;
            pend_addr = mem_req_addr;
            pend_cnt  = $urandom_range(dly_max, dly_min);
        end
    end

    // Reference: delivered instructions form a word stream restarting at each redirect target.
    logic [63:0] exp_pc = RST_PC;
    bit          redir_prev = 1'b0;
    int          outst = 0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [63:0] pa = '0;
    logic [63:0] popped [$];

    initial forever begin
        @(negedge clk);
        #4;
        if (!rst) begin
            chk("rst_mem_req_valid", {63'b0, mem_req_valid}, 64'd0);
            chk("rst_inst_valid", {63'b0, inst_valid}, 64'd0);
            chk("rst_mem_req_addr", mem_req_addr, RST_PC);
            chk("rst_inst", {32'b0, inst}, 64'd0);
            chk("rst_inst_pc", inst_pc, 64'd0);
            exp_pc     = RST_PC;
            redir_prev = 1'b0;
            outst      = 0;
            pv         = 1'b0;
            pr         = 1'b0;
        end else begin
            if (redir_prev) chk("empty_after_redirect", {63'b0, inst_valid}, 64'd0);
            if (pv && !pr) begin
                chk("req_hold_valid", {63'b0, mem_req_valid}, 64'd1);
                chk("req_hold_addr", mem_req_addr, pa);
            end
            if (mem_req_valid) chk("req_addr_aligned", {62'b0, mem_req_addr[1:0]}, 64'd0);
            if (mem_rsp_valid && outst > 0) outst--;
            if (mem_req_valid && mem_req_ready) begin
                outst++;
                chk("one_outstanding", {63'b0, outst <= 1}, 64'd1);
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc & ~64'h3;
            end else if (inst_valid && inst_ready) begin
                chk("inst_pc", inst_pc, exp_pc);
                chk("inst", {32'b0, inst}, {32'b0, exp_pc[31:0]});
                popped.push_back(inst_pc);
                exp_pc = exp_pc + 64'd4;
            end
            redir_prev = redirect_valid;
            pv         = mem_req_valid;
            pr         = mem_req_ready;
            pa         = mem_req_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (mem_req_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(name, {63'b0, ok}, 64'd1);
    endtask

    task automatic wait_pop(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (popped.size() > n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    int          lat;
    int          n0;
    int          cnt;
    bit          ok;
    logic [63:0] lp;
    logic [63:0] a0;

    initial begin
        tick(3);

        // Straight-line fetch from reset with a zero-wait memory
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        rst           = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (inst_valid) begin
                lat = i;
                break;
            end
        end
        chk("first_inst_latency", lat, 3);
        tick(8);
        chk("popped_at_least_3", {63'b0, popped.size() >= 3}, 64'd1);
        if (popped.size() >= 3) begin
            chk("seq_pc0", popped[0], 64'h0000_0000_8000_0000);
            chk("seq_pc1", popped[1], 64'h0000_0000_8000_0004);
            chk("seq_pc2", popped[2], 64'h0000_0000_8000_0008);
        end
        n0 = popped.size();
        tick(40);
        chk("throughput_40_cycles", popped.size() - n0, 20);

        // Decode stall: buffer fills, requests stop, then resume in order
        inst_ready = 1'b0;
        tick(20);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!mem_req_valid) cnt++;
        end
        chk("stall_no_request", cnt, 5);
        chk("stall_inst_valid", {63'b0, inst_valid}, 64'd1);
        lp = popped[$];
        n0 = popped.size();
        inst_ready = 1'b1;
        tick(14);
        chk("resume_pop_count", {63'b0, popped.size() >= n0 + TB_DEPTH + 1}, 64'd1);
        if (popped.size() >= n0 + TB_DEPTH + 1) begin
            chk("resume_first", popped[n0], lp + 64'd4);
            chk("resume_fetched", popped[n0 + TB_DEPTH], lp + 64'd4 * (TB_DEPTH + 1));
        end

        // Memory back-pressure: request held stable
        mem_req_ready = 1'b0;
        wait_req("backpressure_req_seen", ok);
        a0  = mem_req_addr;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_req_valid && mem_req_addr == a0) cnt++;
        end
        chk("backpressure_hold_5", cnt, 5);
        mem_req_ready = 1'b1;

        // Redirect while waiting; the response arrives three cycles later
        tick(4);
        mem_req_ready = 1'b0;
        dly_min = 4;
        dly_max = 4;
        wait_req("redir_wait_req_seen", ok);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_1002;
        @(negedge clk);
        redirect_valid = 1'b0;
        mem_req_ready  = 1'b1;
        wait_req("redir_wait_next_req", ok);
        chk("redir_wait_next_addr", mem_req_addr, 64'h0000_0000_8000_1000);
        chk("redir_wait_fifo_empty", {63'b0, inst_valid}, 64'd0);
        dly_min = 1;
        dly_max = 1;
        tick(6);

        // Redirect coinciding with a response and a pop
        dly_min    = 3;
        dly_max    = 3;
        inst_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (mem_rsp_valid && inst_valid) begin
                redirect_valid = 1'b1;
                redirect_pc    = 64'h0000_0000_8000_2000;
                inst_ready     = 1'b1;
                ok = 1'b1;
                break;
            end
        end
        chk("redir_rsp_setup", {63'b0, ok}, 64'd1);
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("redir_rsp_fifo_empty", {63'b0, inst_valid}, 64'd0);
        wait_req("redir_rsp_next_req", ok);
        chk("redir_rsp_next_addr", mem_req_addr, 64'h0000_0000_8000_2000);
        tick(6);

        // Reset while waiting; the late response must be ignored
        inst_ready    = 1'b1;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_req_valid) break;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midwait_rst_req_valid", {63'b0, mem_req_valid}, 64'd0);
        chk("midwait_rst_addr", mem_req_addr, RST_PC);
        rst = 1'b1;
        n0 = popped.size();
        wait_pop(n0, ok);
        chk("post_reset_pop_seen", {63'b0, ok}, 64'd1);
        if (ok) chk("post_reset_first_pc", popped[n0], RST_PC);

        // Random traffic
        dly_min = 1;
        dly_max = 3;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            mem_req_ready  = ($urandom_range(9, 0) < 7);
            inst_ready     = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(19, 0) == 0);
            if ($urandom_range(9, 0) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFF9;
            else
                redirect_pc = {32'h0, 16'h8000, 16'($urandom)};
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        mem_req_ready  = 1'b1;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
